// File: rtl/fp_add_pkg.sv
// ============================================================================
// fp_add_pkg : shared encodings, format constants and helpers for fp_add
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

package fp_add_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RZ  = 3'b001;
    localparam logic [2:0] RM_RU  = 3'b010;
    localparam logic [2:0] RM_RD  = 3'b011;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    localparam int FLAG_W  = 5;
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam int SP_BIAS     = 127;
    localparam int DP_BIAS     = 1023;
    localparam int SP_TRAP_ADJ = 192;
    localparam int DP_TRAP_ADJ = 1536;

    localparam logic [31:0] SP_QNAN = 32'h7FC0_0000;
    localparam logic [63:0] DP_QNAN = 64'h7FF8_0000_0000_0000;

    // Unbiased exponents span roughly -1090..+1030 plus trap offsets
    typedef logic signed [13:0] exp_t;

    typedef struct packed {
        logic        sign;
        exp_t        exp;
        logic [52:0] mant;
        logic        inf;
        logic        nan;
        logic        snan;
        logic        sub;
    } operand_t;

    // Single fractions are left-aligned into the 52-bit field so both formats share one datapath
    function automatic operand_t fp_unpack(input logic [63:0] x, input logic single);
        operand_t    o;
        logic [10:0] e;
        logic [51:0] f;
        logic        e_max;
        exp_t        bias;
        if (single) begin
            e     = {3'b000, x[62:55]};
            f     = {x[54:32], 29'd0};
            e_max = &x[62:55];
            bias  = exp_t'(SP_BIAS);
        end else begin
            e     = x[62:52];
            f     = x[51:0];
            e_max = &x[62:52];
            bias  = exp_t'(DP_BIAS);
        end
        o.sign = x[63];
        o.inf  = e_max && (f == '0);
        o.nan  = e_max && (f != '0);
        o.snan = o.nan && !f[51];
        o.sub  = (e == 11'd0) && (f != '0);
        o.mant = {(e != 11'd0), f};
        o.exp  = exp_t'({3'b000, ((e == 11'd0) ? 11'd1 : e)}) - bias;
        return o;
    endfunction

    function automatic logic [63:0] fp_pack(input logic sign, input exp_t field,
                                            input logic [52:0] mant, input logic single);
        if (single)
            return {sign, field[7:0], mant[22:0], 32'd0};
        return {sign, field[10:0], mant[51:0]};
    endfunction

    // Right shift that folds every discarded bit into bit 0
    function automatic logic [63:0] shr_jam(input logic [63:0] v, input exp_t sh);
        if (sh > exp_t'(63))
            return {63'd0, |v};
        return (v >> sh[5:0]) | {63'd0, |(v & ((64'd1 << sh[5:0]) - 64'd1))};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_add_if.sv
// ============================================================================
// fp_add_if : operand / result bundle for fp_add
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

interface fp_add_if;
    import fp_add_pkg::*;

    logic [63:0]       op1;
    logic [63:0]       op2;
    logic [2:0]        rm;
    logic [2:0]        op_type;
    logic              P;
    logic              OvEn;
    logic              UnEn;
    logic [63:0]       result;
    logic [FLAG_W-1:0] Flags;
    logic              Denorm;

    modport master (
        output op1, op2, rm, op_type, P, OvEn, UnEn,
        input  result, Flags, Denorm
    );

    modport slave (
        input  op1, op2, rm, op_type, P, OvEn, UnEn,
        output result, Flags, Denorm
    );
endinterface

`default_nettype wire

// File: rtl/fp_add_lzc.sv
// ============================================================================
// fp_add_lzc : 64-bit leading-zero counter (returns 64 for an all-zero input)
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module fp_add_lzc (
    input  logic [63:0] value,
    output logic [6:0]  count
);
    always_comb begin
        count = 7'd64;
        for (int i = 0; i < 64; i++) begin
            if (value[i])
                count = 7'(63 - i);
        end
    end
endmodule

`default_nettype wire

// File: rtl/fp_add.sv
// ============================================================================
// fp_add : one-cycle binary32/binary64 adder/subtractor with IEEE flags.
//          Define FP_ADD_DENORM_EN for gradual underflow; otherwise flush-to-zero.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fp_add
    import fp_add_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    fp_add_if.slave bus
);

`ifdef FP_ADD_DENORM_EN
    localparam bit DENORM_EN = 1'b1;
`else
    localparam bit DENORM_EN = 1'b0;
`endif

    logic        w_single, w_as, w_bs, w_xs, w_swap, w_eff_sub, w_inf_inf, w_to_max;
    logic [2:0]  w_rm;
    operand_t    w_a_raw, w_b_raw;
    exp_t        w_bias, w_emin, w_adj, w_ae, w_be, w_xe, w_ye;
    exp_t        w_exp_n, w_exp_pre, w_exp_f, w_field;
    logic [52:0] w_am, w_bm, w_xm, w_ym, w_mant, w_mant_f;
    logic [53:0] w_mant_r;
    logic [63:0] w_mx, w_my, w_sum, w_norm, w_pre, w_rin, w_res;
    logic [6:0]  w_lz;
    logic        w_tiny, w_rbit, w_sticky, w_inexact, w_inc, w_carry, w_top, w_ovf;
    logic [FLAG_W-1:0] w_flags;

    logic [63:0]       r_result;
    logic [FLAG_W-1:0] r_flags;
    logic              r_denorm;

    assign w_single = bus.P;
    assign w_rm     = bus.rm[2] ? RM_RNE : bus.rm;
    assign w_bias   = w_single ? exp_t'(SP_BIAS) : exp_t'(DP_BIAS);
    assign w_emin   = exp_t'(1) - w_bias;
    assign w_adj    = w_single ? exp_t'(SP_TRAP_ADJ) : exp_t'(DP_TRAP_ADJ);

    assign w_a_raw = fp_unpack(bus.op1, w_single);
    assign w_b_raw = fp_unpack(bus.op2, w_single);
    assign w_as    = w_a_raw.sign;
    assign w_bs    = w_b_raw.sign ^ (bus.op_type == OP_SUB);
    assign w_am    = (!DENORM_EN && w_a_raw.sub) ? '0 : w_a_raw.mant;
    assign w_bm    = (!DENORM_EN && w_b_raw.sub) ? '0 : w_b_raw.mant;
    assign w_ae    = w_a_raw.exp;
    assign w_be    = w_b_raw.exp;

    // x is always the larger magnitude, so a subtraction never goes negative
    assign w_swap    = (w_be > w_ae) || ((w_be == w_ae) && (w_bm > w_am));
    assign w_xs      = w_swap ? w_bs : w_as;
    assign w_xe      = w_swap ? w_be : w_ae;
    assign w_ye      = w_swap ? w_ae : w_be;
    assign w_xm      = w_swap ? w_bm : w_am;
    assign w_ym      = w_swap ? w_am : w_bm;
    assign w_eff_sub = w_as ^ w_bs;

    // Bit 62 holds the hidden bit, bit 63 the carry, ten guard bits below with jammed sticky
    assign w_mx  = {1'b0, w_xm, 10'd0};
    assign w_my  = shr_jam({1'b0, w_ym, 10'd0}, w_xe - w_ye);
    assign w_sum = w_eff_sub ? (w_mx - w_my) : (w_mx + w_my);

    fp_add_lzc u_lzc (
        .value (w_sum),
        .count (w_lz)
    );

    // After the shift bit 63 carries weight 2^w_exp_n
    assign w_norm  = w_sum << w_lz[5:0];
    assign w_exp_n = w_xe + exp_t'(1) - exp_t'({7'd0, w_lz});
    assign w_tiny  = w_exp_n < w_emin;

    always_comb begin
        w_pre     = w_norm;
        w_exp_pre = w_exp_n;
        if (DENORM_EN && w_tiny && !bus.UnEn) begin
            w_pre     = shr_jam(w_norm, w_emin - w_exp_n);
            w_exp_pre = w_emin;
        end
    end

    // Single precision rounds 29 bits higher; slide it down so one rounder serves both
    assign w_rin     = w_single ? ({29'd0, w_pre[63:29]} | {63'd0, |w_pre[28:0]}) : w_pre;
    assign w_mant    = w_rin[63:11];
    assign w_rbit    = w_rin[10];
    assign w_sticky  = |w_rin[9:0];
    assign w_inexact = w_rbit | w_sticky;

    always_comb begin
        case (w_rm)
            RM_RZ:   w_inc = 1'b0;
            RM_RU:   w_inc = !w_xs && w_inexact;
            RM_RD:   w_inc = w_xs && w_inexact;
            default: w_inc = w_rbit && (w_sticky || w_mant[0]);
        endcase
    end

    assign w_mant_r = {1'b0, w_mant} + {53'd0, w_inc};
    assign w_carry  = w_single ? w_mant_r[24] : w_mant_r[53];
    assign w_mant_f = w_carry ? w_mant_r[53:1] : w_mant_r[52:0];
    assign w_exp_f  = w_exp_pre + exp_t'({13'd0, w_carry});
    assign w_top    = w_single ? w_mant_f[23] : w_mant_f[52];
    assign w_field  = w_top ? (w_exp_f + w_bias) : exp_t'(0);
    assign w_ovf    = w_top && (w_exp_f > w_bias);

    assign w_inf_inf = w_a_raw.inf && w_b_raw.inf && w_eff_sub;
    assign w_to_max  = (w_rm == RM_RZ) || ((w_rm == RM_RU) && w_xs) || ((w_rm == RM_RD) && !w_xs);

    always_comb begin
        w_res            = fp_pack(w_xs, w_field, w_mant_f, w_single);
        w_flags          = '0;
        w_flags[FLAG_DZ] = 1'b0;
        if (w_a_raw.nan || w_b_raw.nan || w_inf_inf) begin
            w_res            = w_single ? {SP_QNAN, 32'd0} : DP_QNAN;
            w_flags[FLAG_NV] = w_a_raw.snan || w_b_raw.snan || w_inf_inf;
        end else if (w_a_raw.inf || w_b_raw.inf) begin
            w_res = fp_pack(w_a_raw.inf ? w_as : w_bs, w_bias + w_bias + exp_t'(1), '0, w_single);
        end else if (w_sum == '0) begin
            w_res = fp_pack(w_eff_sub ? (w_rm == RM_RD) : w_xs, exp_t'(0), '0, w_single);
        end else if (!DENORM_EN && w_tiny && !bus.UnEn) begin
            w_res            = fp_pack(w_xs, exp_t'(0), '0, w_single);
            w_flags[FLAG_UF] = 1'b1;
            w_flags[FLAG_NX] = 1'b1;
        end else if (w_ovf) begin
            w_flags[FLAG_OF] = 1'b1;
            w_flags[FLAG_NX] = 1'b1;
            if (bus.OvEn)
                w_res = fp_pack(w_xs, w_field - w_adj, w_mant_f, w_single);
            else if (w_to_max)
                w_res = fp_pack(w_xs, w_bias + w_bias, '1, w_single);
            else
                w_res = fp_pack(w_xs, w_bias + w_bias + exp_t'(1), '0, w_single);
        end else begin
            w_flags[FLAG_NX] = w_inexact;
            w_flags[FLAG_UF] = w_tiny && (bus.UnEn || w_inexact);
            if (w_tiny && bus.UnEn)
                w_res = fp_pack(w_xs, w_field + w_adj, w_mant_f, w_single);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result <= '0;
            r_flags  <= '0;
            r_denorm <= 1'b0;
        end else begin
            r_result <= w_res;
            r_flags  <= w_flags;
            r_denorm <= w_a_raw.sub || w_b_raw.sub;
        end
    end

    assign bus.result = r_result;
    assign bus.Flags  = r_flags;
    assign bus.Denorm = r_denorm;

endmodule

`default_nettype wire

// File: tb/tb_fp_add.sv
// ============================================================================
// tb_fp_add : directed vectors checked through an expected-result queue
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module tb_fp_add;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RZ  = 3'b001;
    localparam logic [2:0] RU  = 3'b010;
    localparam logic [2:0] RD  = 3'b011;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  flags;
        logic        den;
        int          id;
    } expect_t;

    logic    clk   = 1'b0;
    logic    reset = 1'b0;
    logic    valid = 1'b0;
    logic    pend  = 1'b0;
    int      checks = 0;
    int      errors = 0;
    int      nvec   = 0;
    expect_t sb[$];

    always #5 clk = ~clk;

    fp_add_if bus ();

    fp_add dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clk) pend <= valid;

    always @(negedge clk) begin : monitor
        expect_t e;
        if (pend) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: output present with no expected entry, result=%h", bus.result);
            end else begin
                e = sb.pop_front();
                if (bus.result !== e.res || bus.Flags !== e.flags || bus.Denorm !== e.den) begin
                    errors++;
                    $display("FAIL vec%0d: got result=%h flags=%h denorm=%b, expected result=%h flags=%h denorm=%b",
                             e.id, bus.result, bus.Flags, bus.Denorm, e.res, e.flags, e.den);
                end
            end
        end
    end

    task automatic drive(input logic p, input logic [2:0] ot, input logic [2:0] rm,
                         input logic ov, input logic un, input logic [63:0] a, input logic [63:0] b);
        bus.P       = p;
        bus.op_type = ot;
        bus.rm      = rm;
        bus.OvEn    = ov;
        bus.UnEn    = un;
        bus.op1     = a;
        bus.op2     = b;
    endtask

    task automatic vec(input logic p, input logic [2:0] ot, input logic [2:0] rm,
                       input logic ov, input logic un, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] er, input logic [4:0] ef, input logic ed);
        expect_t e;
        @(negedge clk);
        drive(p, ot, rm, ov, un, a, b);
        valid = 1'b1;
        e.res   = er;
        e.flags = ef;
        e.den   = ed;
        e.id    = nvec;
        sb.push_back(e);
        nvec++;
    endtask

    task automatic check(input string name, input logic [69:0] got, input logic [69:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    initial begin
        drive(1'b1, SUB, RU, 1'b0, 1'b0, 64'h00000001_00000000, 64'h3F800000_00000000);
        #1;
        check("reset_state", {bus.result, bus.Flags, bus.Denorm}, 70'd0);
        @(posedge clk);
        #1;
        check("reset_state_clocked", {bus.result, bus.Flags, bus.Denorm}, 70'd0);
        @(negedge clk);
        reset = 1'b1;

        vec(1, SUB, RU,  0, 0, 64'h3F800000_00000000, 64'h3F800000_00000000, 64'h00000000_00000000, 5'h00, 0);
        vec(1, SUB, RD,  0, 0, 64'h3F800000_00000000, 64'h3F800000_00000000, 64'h80000000_00000000, 5'h00, 0);
        vec(1, SUB, RU,  0, 0, 64'h3F800000_00000000, 64'h33000000_00000000, 64'h3F800000_00000000, 5'h01, 0);
        vec(1, SUB, RZ,  0, 0, 64'h3F800000_00000000, 64'h33000000_00000000, 64'h3F7FFFFF_00000000, 5'h01, 0);
        vec(1, SUB, RU,  0, 0, 64'h7F7FFFFF_00000000, 64'hFF7FFFFF_00000000, 64'h7F800000_00000000, 5'h05, 0);
        vec(1, SUB, RZ,  0, 0, 64'h7F7FFFFF_00000000, 64'hFF7FFFFF_00000000, 64'h7F7FFFFF_00000000, 5'h05, 0);
        vec(1, SUB, RU,  1, 0, 64'h7F7FFFFF_00000000, 64'hFF7FFFFF_00000000, 64'h1FFFFFFF_00000000, 5'h05, 0);
        vec(1, ADD, RNE, 0, 0, 64'h7F7FFFFF_00000000, 64'h7F7FFFFF_00000000, 64'h7F800000_00000000, 5'h05, 0);
        vec(1, ADD, RD,  0, 0, 64'h7F7FFFFF_00000000, 64'h7F7FFFFF_00000000, 64'h7F7FFFFF_00000000, 5'h05, 0);
        vec(1, SUB, RNE, 0, 0, 64'h7F800000_00000000, 64'h7F800000_00000000, 64'h7FC00000_00000000, 5'h10, 0);
        vec(1, ADD, RNE, 0, 0, 64'h7FA00000_00000000, 64'h3F800000_00000000, 64'h7FC00000_00000000, 5'h10, 0);
        vec(1, ADD, RNE, 0, 0, 64'h7FC00000_00000000, 64'h3F800000_00000000, 64'h7FC00000_00000000, 5'h00, 0);
        vec(1, ADD, RNE, 0, 0, 64'hFF800000_00000000, 64'h3F800000_00000000, 64'hFF800000_00000000, 5'h00, 0);
        vec(1, ADD, RNE, 0, 0, 64'h80000000_00000000, 64'h80000000_00000000, 64'h80000000_00000000, 5'h00, 0);
        vec(0, ADD, RNE, 0, 0, 64'h3FF00000_00000000, 64'h3FF00000_00000000, 64'h40000000_00000000, 5'h00, 0);
        vec(0, SUB, RNE, 0, 0, 64'h3FF00000_00000000, 64'h3FF00000_00000000, 64'h00000000_00000000, 5'h00, 0);
        vec(0, ADD, RNE, 0, 0, 64'h7FF00000_00000001, 64'h00000000_00000000, 64'h7FF80000_00000000, 5'h10, 0);
        // rm=100 must round like nearest-even: exact tie stays on the even value
        vec(1, ADD, 3'b100, 0, 0, 64'h3F800000_00000000, 64'h33800000_00000000, 64'h3F800000_00000000, 5'h01, 0);
        vec(1, ADD, RU,  0, 0, 64'h3F800000_00000000, 64'h33800000_00000000, 64'h3F800001_00000000, 5'h01, 0);
        vec(1, 3'b111, RNE, 0, 0, 64'h3F800000_DEADBEEF, 64'h3F800000_12345678, 64'h40000000_00000000, 5'h00, 0);
        vec(1, SUB, RNE, 0, 1, 64'h00C00000_00000000, 64'h00800000_00000000, 64'h60000000_00000000, 5'h02, 0);
`ifdef FP_ADD_DENORM_EN
        vec(1, SUB, RU,  0, 0, 64'h00000001_00000000, 64'h00000002_00000000, 64'h80000001_00000000, 5'h00, 1);
        vec(1, SUB, RNE, 0, 0, 64'h00C00000_00000000, 64'h00800000_00000000, 64'h00400000_00000000, 5'h00, 0);
`else
        vec(1, SUB, RU,  0, 0, 64'h00000001_00000000, 64'h00000002_00000000, 64'h00000000_00000000, 5'h00, 1);
        vec(1, SUB, RNE, 0, 0, 64'h00C00000_00000000, 64'h00800000_00000000, 64'h00000000_00000000, 5'h03, 0);
`endif

        // Load a result, then drop reset between edges: outputs must clear immediately
        @(negedge clk);
        valid = 1'b0;
        drive(1'b1, SUB, RU, 1'b0, 1'b0, 64'h3F800000_00000000, 64'h00000001_00000000);
        @(posedge clk);
        #2;
        check("pre_reset_output", {bus.result, bus.Denorm}, {6'd0, 64'h3F800000_00000000, 1'b1} >> 0);
        reset = 1'b0;
        #1;
        check("reset_async_clear", {bus.result, bus.Flags, bus.Denorm}, 70'd0);
        @(posedge clk);
        #1;
        check("reset_hold_clear", {bus.result, bus.Flags, bus.Denorm}, 70'd0);
        @(negedge clk);
        reset = 1'b1;

        vec(0, ADD, RNE, 0, 0, 64'h3FF00000_00000000, 64'h3FF00000_00000000, 64'h40000000_00000000, 5'h00, 0);
        @(negedge clk);
        valid = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 70'(sb.size()), 70'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
